// File: rtl/alu_mc.sv
// Multi-cycle ALU with a registered result and an iterative restoring divider.
//
// Parameters:
//   DATA_WIDTH  operand width of A and B
//   FUN_WIDTH   opcode width; opcodes with any bit above bit 3 set act as NOP
// Ports:
//   CLK         clock, all state updates on the rising edge
//   RST         synchronous active-high reset
//   A, B        unsigned operands
//   ALU_FUN     operation code
//   ALU_EN      request, accepted on an edge where ALU_EN=1 and BUSY=0
//   ALU_OUT     registered result, 2*DATA_WIDTH bits
//   OUT_VALID   one-cycle pulse marking a new ALU_OUT
//   BUSY        high while an iterative divide is running
//   ZERO_FLAG   new ALU_OUT is zero
//   CARRY_FLAG  carry out of ADD / borrow of SUB, else 0
//   DIV_ERR     divide by zero
module alu_mc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  input  logic [FUN_WIDTH-1:0]    ALU_FUN,
  input  logic                    ALU_EN,
  output logic [2*DATA_WIDTH-1:0] ALU_OUT,
  output logic                    OUT_VALID,
  output logic                    BUSY,
  output logic                    ZERO_FLAG,
  output logic                    CARRY_FLAG,
  output logic                    DIV_ERR
);

  localparam int unsigned OUT_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned CntW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpMul = 4'h2;
  localparam logic [3:0] OpDiv = 4'h3;

  typedef enum logic [0:0] {StIdle, StDiv} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   quo_q, quo_d;
  logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
  logic [OUT_WIDTH-1:0]    alu_out_q, alu_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    zero_q, zero_d;
  logic                    carry_q, carry_d;
  logic                    div_err_q, div_err_d;

  // Single-cycle datapath
  logic [3:0]            op;
  logic                  op_legal;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] logic_r;
  logic [OUT_WIDTH-1:0]  a_ext, b_ext, res;
  logic                  carry_res;

  assign op       = ALU_FUN[3:0];
  assign op_legal = (ALU_FUN >> 4) == '0;
  assign a_ext    = {{DATA_WIDTH{1'b0}}, A};
  assign b_ext    = {{DATA_WIDTH{1'b0}}, B};
  assign sum      = {1'b0, A} + {1'b0, B};

  always_comb begin
    res       = '0;
    carry_res = 1'b0;
    logic_r   = '0;
    if (op_legal) begin
      case (op)
        4'h0: begin
          res       = {{(DATA_WIDTH - 1){1'b0}}, sum};
          carry_res = sum[DATA_WIDTH];
        end
        4'h1: begin
          res       = a_ext - b_ext;
          carry_res = (A < B);
        end
        4'h2: res = a_ext * b_ext;
        // Only reached with B=0; non-zero divisors go through the iterative path.
        4'h3: res = '1;
        4'h4: begin logic_r = A & B;    res = {{DATA_WIDTH{1'b0}}, logic_r}; end
        4'h5: begin logic_r = A | B;    res = {{DATA_WIDTH{1'b0}}, logic_r}; end
        4'h6: begin logic_r = ~(A & B); res = {{DATA_WIDTH{1'b0}}, logic_r}; end
        4'h7: begin logic_r = ~(A | B); res = {{DATA_WIDTH{1'b0}}, logic_r}; end
        4'h9: res = (A == B) ? OUT_WIDTH'(1) : '0;
        4'hA: res = (A > B)  ? OUT_WIDTH'(2) : '0;
        4'hB: res = (A < B)  ? OUT_WIDTH'(3) : '0;
        4'hC: res = a_ext >> 1;
        4'hD: res = a_ext << 1;
        4'hE: res = b_ext >> 1;
        4'hF: res = b_ext << 1;
        default: res = '0;
      endcase
    end
  end

  // Restoring divide step: shift the next dividend bit into the partial remainder and subtract
  // the divisor if it fits. Bit DATA_WIDTH of the trial difference is the borrow.
  logic [DATA_WIDTH:0]   shifted, trial;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] rem_step, quo_step;

  always_comb begin
    shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    q_bit    = ~trial[DATA_WIDTH];
    rem_step = q_bit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    quo_step = (quo_q << 1) | DATA_WIDTH'(q_bit);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    alu_out_d   = alu_out_q;
    out_valid_d = 1'b0;
    zero_d      = zero_q;
    carry_d     = carry_q;
    div_err_d   = div_err_q;
    case (state_q)
      StIdle: begin
        if (ALU_EN) begin
          if (op_legal && (op == OpDiv) && (B != '0)) begin
            state_d = StDiv;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = A;
            dvs_d   = B;
          end else begin
            alu_out_d   = res;
            out_valid_d = 1'b1;
            zero_d      = (res == '0);
            carry_d     = carry_res & ((op == OpAdd) || (op == OpSub)) & op_legal;
            div_err_d   = op_legal && (op == OpDiv);
          end
        end
      end
      StDiv: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
          state_d     = StIdle;
          alu_out_d   = {rem_step, quo_step};
          out_valid_d = 1'b1;
          zero_d      = (rem_step == '0) && (quo_step == '0);
          carry_d     = 1'b0;
          div_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      alu_out_q   <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      alu_out_q   <= alu_out_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      div_err_q   <= div_err_d;
    end
  end

  assign ALU_OUT    = alu_out_q;
  assign OUT_VALID  = out_valid_q;
  assign BUSY       = (state_q == StDiv);
  assign ZERO_FLAG  = zero_q;
  assign CARRY_FLAG = carry_q;
  assign DIV_ERR    = div_err_q;

  // Keeps OpMul referenced for readers scanning the opcode map.
  logic unused_op;
  assign unused_op = (OpMul == 4'h2) & (OpSub == 4'h1);

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (DATA_WIDTH=8): directed literal cases plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_alu_mc;

  localparam int DW = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  A, B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID, BUSY, ZERO_FLAG, CARRY_FLAG, DIV_ERR;

  always #5 CLK = ~CLK;

  alu_mc dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .ALU_EN    (ALU_EN),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .BUSY      (BUSY),
    .ZERO_FLAG (ZERO_FLAG),
    .CARRY_FLAG(CARRY_FLAG),
    .DIV_ERR   (DIV_ERR)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        e;
  } ref_t;

  // Result of one operation from plain integer arithmetic.
  function automatic ref_t ref_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    ref_t o;
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    o  = '0;
    case (f)
      4'h0: begin o.r = 16'(ai + bi); o.c = (ai + bi) > 255; end
      4'h1: begin o.r = 16'(ai - bi); o.c = ai < bi; end
      4'h2: o.r = 16'(ai * bi);
      4'h3: begin
        if (bi == 0) begin
          o.r = 16'hFFFF;
          o.e = 1'b1;
        end else begin
          o.r = 16'((ai % bi) * 256 + ai / bi);
        end
      end
      4'h4: o.r = 16'(ai & bi);
      4'h5: o.r = 16'(ai | bi);
      4'h6: o.r = 16'(255 - (ai & bi));
      4'h7: o.r = 16'(255 - (ai | bi));
      4'h9: o.r = (ai == bi) ? 16'd1 : 16'd0;
      4'hA: o.r = (ai > bi) ? 16'd2 : 16'd0;
      4'hB: o.r = (ai < bi) ? 16'd3 : 16'd0;
      4'hC: o.r = 16'(ai / 2);
      4'hD: o.r = 16'(ai * 2);
      4'hE: o.r = 16'(bi / 2);
      4'hF: o.r = 16'(bi * 2);
      default: o.r = 16'd0;
    endcase
    return o;
  endfunction

  // Transaction-level model: m_pend counts the edges left until a running divide reports.
  ref_t        m_ref;
  logic [15:0] m_out, m_pres;
  logic        m_valid, m_busy, m_zero, m_carry, m_err;
  int          m_pend;
  logic        m_ready = 1'b0;

  assign m_ref = ref_op(ALU_FUN, A, B);

  always @(posedge CLK) begin
    m_ready <= 1'b1;
    if (RST) begin
      m_out <= 16'd0; m_valid <= 1'b0; m_busy <= 1'b0;
      m_zero <= 1'b0; m_carry <= 1'b0; m_err <= 1'b0;
      m_pend <= 0; m_pres <= 16'd0;
    end else begin
      m_valid <= 1'b0;
      if (m_pend > 0) begin
        m_pend <= m_pend - 1;
        if (m_pend == 1) begin
          m_out <= m_pres; m_valid <= 1'b1; m_busy <= 1'b0;
          m_zero <= (m_pres == 16'd0); m_carry <= 1'b0; m_err <= 1'b0;
        end
      end else if (ALU_EN) begin
        if (ALU_FUN == 4'h3 && B != 8'd0) begin
          m_pend <= DW; m_busy <= 1'b1; m_pres <= m_ref.r;
        end else begin
          m_out <= m_ref.r; m_valid <= 1'b1; m_zero <= (m_ref.r == 16'd0);
          m_carry <= m_ref.c; m_err <= m_ref.e;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (m_ready) begin
      chk("cmp_alu_out",   {16'd0, ALU_OUT},   {16'd0, m_out});
      chk("cmp_out_valid", {31'd0, OUT_VALID}, {31'd0, m_valid});
      chk("cmp_busy",      {31'd0, BUSY},      {31'd0, m_busy});
      chk("cmp_zero",      {31'd0, ZERO_FLAG}, {31'd0, m_zero});
      chk("cmp_carry",     {31'd0, CARRY_FLAG},{31'd0, m_carry});
      chk("cmp_div_err",   {31'd0, DIV_ERR},   {31'd0, m_err});
    end
  end

  // Drive one request for one edge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    ALU_FUN = f; A = a; B = b; ALU_EN = 1'b1;
    @(negedge CLK);
    ALU_EN = 1'b0;
  endtask

  task automatic chk_result(input string name, input logic [15:0] out, input logic z,
                            input logic c, input logic e);
    chk({name, "_out"},   {16'd0, ALU_OUT},    {16'd0, out});
    chk({name, "_valid"}, {31'd0, OUT_VALID},  32'd1);
    chk({name, "_zero"},  {31'd0, ZERO_FLAG},  {31'd0, z});
    chk({name, "_carry"}, {31'd0, CARRY_FLAG}, {31'd0, c});
    chk({name, "_err"},   {31'd0, DIV_ERR},    {31'd0, e});
  endtask

  initial begin
    RST = 1'b1; ALU_EN = 1'b0; A = 8'd0; B = 8'd0; ALU_FUN = 4'h0;
    repeat (2) @(negedge CLK);
    chk("reset_out",   {16'd0, ALU_OUT}, 32'd0);
    chk("reset_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("reset_busy",  {31'd0, BUSY}, 32'd0);

    // Reset wins over a simultaneous request.
    ALU_EN = 1'b1; ALU_FUN = 4'h0; A = 8'd1; B = 8'd1;
    @(negedge CLK);
    chk("rst_prio_valid", {31'd0, OUT_VALID}, 32'd0);
    RST = 1'b0;

    // First edge with RST low accepts.
    issue(4'h0, 8'd200, 8'd100); chk_result("add", 16'h012C, 1'b0, 1'b1, 1'b0);
    issue(4'h1, 8'd2,   8'd5);   chk_result("sub", 16'hFFFD, 1'b0, 1'b1, 1'b0);
    issue(4'h2, 8'd255, 8'd255); chk_result("mul", 16'hFE01, 1'b0, 1'b0, 1'b0);
    issue(4'h6, 8'd5,   8'd4);   chk_result("nand", 16'h00FB, 1'b0, 1'b0, 1'b0);
    issue(4'h7, 8'd5,   8'd2);   chk_result("nor", 16'h00F8, 1'b0, 1'b0, 1'b0);
    issue(4'hD, 8'h81,  8'd0);   chk_result("shl_a", 16'h0102, 1'b0, 1'b0, 1'b0);
    issue(4'h3, 8'd9,   8'd0);   chk_result("div0", 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("div0_busy", {31'd0, BUSY}, 32'd0);
    issue(4'h0, 8'd0,   8'd0);   chk_result("add00", 16'h0000, 1'b1, 1'b0, 1'b0);
    issue(4'h9, 8'd5,   8'd5);   chk_result("eq",  16'd1, 1'b0, 1'b0, 1'b0);
    issue(4'hA, 8'd5,   8'd2);   chk_result("gt",  16'd2, 1'b0, 1'b0, 1'b0);
    issue(4'hB, 8'd2,   8'd5);   chk_result("lt",  16'd3, 1'b0, 1'b0, 1'b0);
    issue(4'hB, 8'd5,   8'd2);   chk_result("nlt", 16'd0, 1'b1, 1'b0, 1'b0);

    // DIV 200/7 with an ADD request and operand changes during BUSY.
    issue(4'h3, 8'd200, 8'd7);
    for (int i = 0; i < DW; i++) begin
      chk("div_busy",  {31'd0, BUSY}, 32'd1);
      chk("div_novalid", {31'd0, OUT_VALID}, 32'd0);
      if (i == 2) begin ALU_EN = 1'b1; ALU_FUN = 4'h0; A = 8'd1; B = 8'd1; end
      if (i == 3) ALU_EN = 1'b0;
      @(negedge CLK);
    end
    chk_result("div", 16'h041C, 1'b0, 1'b0, 1'b0);
    chk("div_done_busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    chk("div_hold_out",  {16'd0, ALU_OUT}, 32'h041C);
    chk("div_ignored_add", {31'd0, OUT_VALID}, 32'd0);

    // Reset on the 4th divide cycle aborts silently.
    issue(4'h3, 8'd100, 8'd3);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rstdiv_out",  {16'd0, ALU_OUT}, 32'd0);
    chk("rstdiv_busy", {31'd0, BUSY}, 32'd0);
    repeat (DW + 1) begin
      @(negedge CLK);
      chk("rstdiv_novalid", {31'd0, OUT_VALID}, 32'd0);
    end
    issue(4'h0, 8'd1, 8'd1); chk_result("add11", 16'd2, 1'b0, 1'b0, 1'b0);

    // Randomized traffic; the compare process checks every cycle.
    repeat (800) begin
      RST     = ($urandom_range(0, 149) == 0);
      ALU_EN  = ($urandom_range(0, 1) == 1);
      ALU_FUN = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ALU_FUN = 4'h3;
      A = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      B = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      @(negedge CLK);
    end
    RST = 1'b0; ALU_EN = 1'b0;
    repeat (DW + 3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of the operands A and B.
REQ-002 The block SHALL have parameter FUN_WIDTH, default 4, giving the width of the ALU_FUN opcode.
REQ-003 The block SHALL have local parameter OUT_WIDTH = 2*DATA_WIDTH, which SHALL NOT be overridable.
REQ-004 Port CLK: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 Port RST: input, 1 bit, reset; reset is synchronous and active-high.
REQ-006 Port A: input, DATA_WIDTH bits, operand A (unsigned).
REQ-007 Port B: input, DATA_WIDTH bits, operand B (unsigned).
REQ-008 Port ALU_FUN: input, FUN_WIDTH bits, operation code.
REQ-009 Port ALU_EN: input, 1 bit, request; a request is accepted on a rising edge where ALU_EN=1 and BUSY=0.
REQ-010 Port ALU_OUT: output, OUT_WIDTH bits, registered result.
REQ-011 Port OUT_VALID: output, 1 bit, one-cycle pulse marking a new ALU_OUT.
REQ-012 Port BUSY: output, 1 bit, high while an iterative divide is in progress.
REQ-013 Port ZERO_FLAG: output, 1 bit, set when the new ALU_OUT equals 0, updated together with OUT_VALID.
REQ-014 Port CARRY_FLAG: output, 1 bit, holds bit DATA_WIDTH of A+B for ADD and the borrow (A<B) for SUB, and SHALL be 0 for all other operations.
REQ-015 Port DIV_ERR: output, 1 bit, set when a DIV had B=0, updated together with OUT_VALID.

Function
REQ-016 The opcodes SHALL be:
- 0000 ADD A+B
- 0001 SUB A-B, two's complement over OUT_WIDTH bits
- 0010 MUL A*B, full OUT_WIDTH-bit product
- 0011 DIV: quotient in ALU_OUT[DATA_WIDTH-1:0], remainder in ALU_OUT[OUT_WIDTH-1:DATA_WIDTH]
- 0100 AND, 0101 OR, 0110 NAND, 0111 NOR: DATA_WIDTH-bit results, zero-extended
- 1000 NOP, result 0
- 1001 result 1 if A==B, else 0
- 1010 result 2 if A>B, else 0
- 1011 result 3 if A<B, else 0
- 1100 A>>1, 1101 A<<1, 1110 B>>1, 1111 B<<1: logical shifts computed in OUT_WIDTH bits, so the bit shifted out by a left shift is kept
REQ-017 The state machine SHALL have the states IDLE and DIV.
REQ-018 In IDLE, a non-DIV request, or a DIV request with B=0, SHALL load ALU_OUT and the flags and pulse OUT_VALID on the edge following acceptance (latency 1), and SHALL remain in IDLE.
REQ-019 In IDLE, a DIV request with B≠0 SHALL latch A and B, enter DIV, and assert BUSY from the edge following acceptance.
REQ-020 In DIV, the block SHALL perform one restoring shift-subtract step per cycle for exactly DATA_WIDTH cycles.
REQ-021 On the edge of the final DIV step, the block SHALL register the quotient and remainder and pulse OUT_VALID, deassert BUSY, and return to IDLE.
REQ-022 DIV with B≠0 SHALL have a total latency of DATA_WIDTH+1 edges from acceptance to OUT_VALID.
REQ-023 ALU_EN asserted while BUSY=1 SHALL be ignored; requests SHALL NOT be queued.
REQ-024 A new request SHALL be accepted on the same edge on which BUSY falls to 0 only if BUSY was already 0 at that edge; the earliest back-to-back request after a DIV is therefore on the next edge.
REQ-025 A DIV with B=0 SHALL produce ALU_OUT = all ones, DIV_ERR=1, ZERO_FLAG=0, with latency 1.
REQ-026 Changes to A, B or ALU_FUN after acceptance SHALL NOT affect an in-progress DIV.
REQ-027 ALU_OUT and all flags SHALL hold their last values until the next OUT_VALID.
REQ-028 OUT_VALID SHALL be 0 in every cycle in which no result is produced.
REQ-029 Undefined opcodes (FUN_WIDTH > 4, upper bits ≠ 0) SHALL behave as NOP.

Reset
REQ-030 While RST=1 at a rising edge, the block SHALL set state to IDLE, ALU_OUT to 0, and OUT_VALID, BUSY, ZERO_FLAG, CARRY_FLAG and DIV_ERR to 0.
REQ-031 RST asserted mid-DIV SHALL abort the operation with no OUT_VALID pulse.
REQ-032 RST SHALL take priority over ALU_EN on the same edge.
REQ-033 The first request SHALL be accepted on the first edge with RST=0.

Verification (DATA_WIDTH=8)
REQ-034 ADD 200+100 -> ALU_OUT=0x012C, CARRY_FLAG=1, OUT_VALID pulse 1 cycle after acceptance; SUB 2-5 -> 0xFFFD, CARRY_FLAG=1.
REQ-035 MUL 255*255 -> 0xFE01; NAND 5,4 -> 0x00FB; NOR 5,2 -> 0x00F8; A<<1 with A=0x81 -> 0x0102.
REQ-036 DIV 200/7 -> BUSY high for 8 cycles, then ALU_OUT=0x041C (remainder 4, quotient 28), OUT_VALID 9 edges after acceptance; an ALU_EN with ADD applied during BUSY produces no result.
REQ-037 DIV 9/0 -> ALU_OUT=0xFFFF, DIV_ERR=1, BUSY stays 0, latency 1; the next ADD 0+0 -> ALU_OUT=0, ZERO_FLAG=1, DIV_ERR=0.
REQ-038 Compare ops: 5==5 -> 1, 5>2 -> 2, 2<5 -> 3, 5<2 -> 0 with ZERO_FLAG=1.
REQ-039 Reset mid-DIV: RST on the 4th DIV cycle -> all outputs 0, no OUT_VALID, and a new ADD 1+1 accepted after reset -> ALU_OUT=2.
